// File: rtl/issue_select_pkg.sv
// Shared sizing for the reservation-station issue path: entry count, entry
// index type and the deepest supported FU wakeup latency.
package issue_select_pkg;

  localparam int NUM_RS_ENTRIES = 8;
  localparam int RS_IDX_W       = $clog2(NUM_RS_ENTRIES);
  localparam int FU_LATENCY_MAX = 4;

  typedef logic [RS_IDX_W-1:0] rs_idx_t;

endpackage

// File: rtl/issue_select_age_matrix.sv
// Age tracking for reservation-station entries: keeps allocation order and
// produces a one-hot grant for the oldest valid entry that is also ready.
module age_matrix
  import issue_select_pkg::*;
#(
  parameter int NUM_ROWS = NUM_RS_ENTRIES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_flush,
  input  logic                        i_alloc_en,
  input  logic [$clog2(NUM_ROWS)-1:0] i_alloc_idx,
  input  logic                        i_free_en,
  input  logic [$clog2(NUM_ROWS)-1:0] i_free_idx,
  input  logic [NUM_ROWS-1:0]         i_ready,
  output logic [NUM_ROWS-1:0]         o_grant
);

  // r_older_col[i][j] = 1 means entry j was allocated before entry i.
  logic [NUM_ROWS-1:0] r_older_col [NUM_ROWS];
  logic [NUM_ROWS-1:0] r_valid;
  logic [NUM_ROWS-1:0] w_rv;

  assign w_rv = i_ready & r_valid;

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      o_grant[i] = w_rv[i] & ~(|(w_rv & r_older_col[i]));
    end
  end

  // Stale age bits of freed entries are harmless: every use is masked by r_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        r_older_col[i] <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      if (i_free_en) begin
        r_valid[i_free_idx] <= 1'b0;
      end
      if (i_alloc_en) begin
        r_valid[i_alloc_idx] <= 1'b1;
        for (int i = 0; i < NUM_ROWS; i++) begin
          r_older_col[i][i_alloc_idx] <= 1'b0;
        end
        r_older_col[i_alloc_idx] <= r_valid;
      end
    end
  end

  a_alloc_free_row : assert property (@(posedge clk) disable iff (!rst)
    !(i_alloc_en && !i_flush && r_valid[i_alloc_idx]));

endmodule

// File: rtl/issue_select.sv
// Oldest-first issue picker with a valid/ready issue register toward the FU
// and a fixed-latency wakeup broadcast. Optional counters: ISSUE_SELECT_STATS_EN.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int NUM_ROWS   = NUM_RS_ENTRIES,
  parameter int FU_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_en,
  input  logic [$clog2(NUM_ROWS)-1:0] alloc_row_index,
  input  logic [NUM_ROWS-1:0]         ready_vector,
  output logic                        free_en,
  output logic [$clog2(NUM_ROWS)-1:0] free_row_index,
  output logic                        issue_valid,
  output logic [$clog2(NUM_ROWS)-1:0] issue_row_index,
  input  logic                        issue_ready,
  output logic                        clear_en,
`ifdef ISSUE_SELECT_STATS_EN
  output logic [NUM_ROWS-1:0]         clear_lines,
  output logic [31:0]                 stat_issued,
  output logic [31:0]                 stat_stall
`else
  output logic [NUM_ROWS-1:0]         clear_lines
`endif
);

  localparam int IDX_W = $clog2(NUM_ROWS);

  if (FU_LATENCY < 1 || FU_LATENCY > FU_LATENCY_MAX) begin : g_bad_latency
    $error("issue_select: FU_LATENCY out of range");
  end

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_ROWS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (oh[k]) idx = idx | IDX_W'(k);
    end
    return idx;
  endfunction

  logic [NUM_ROWS-1:0] w_grant;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_can_load;
  logic                w_sel;
  logic                w_hs;

  logic                r_issue_valid;
  logic [IDX_W-1:0]    r_issue_idx;
  logic [FU_LATENCY-1:0] r_wk_vld;
  logic [IDX_W-1:0]    r_wk_idx [FU_LATENCY];

  age_matrix #(
    .NUM_ROWS (NUM_ROWS)
  ) u_age_matrix (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_alloc_en  (alloc_en),
    .i_alloc_idx (alloc_row_index),
    .i_free_en   (w_sel),
    .i_free_idx  (w_sel_idx),
    .i_ready     (ready_vector),
    .o_grant     (w_grant)
  );

  // Select stage: pick oldest ready entry when the issue register can accept.
  assign w_can_load     = ~r_issue_valid | issue_ready;
  assign w_sel          = (|w_grant) & w_can_load & ~flush;
  assign w_sel_idx      = onehot_to_idx(w_grant);
  assign w_hs           = r_issue_valid & issue_ready;

  assign free_en        = w_sel;
  assign free_row_index = w_sel ? w_sel_idx : '0;

  // Issue register stage: holds the selected entry until the FU accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
    end else if (flush) begin
      r_issue_valid <= 1'b0;
    end else if (w_sel) begin
      r_issue_valid <= 1'b1;
      r_issue_idx   <= w_sel_idx;
    end else if (issue_ready) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign issue_valid     = r_issue_valid;
  assign issue_row_index = r_issue_idx;

  // Wakeup pipe stage: free-running shift from FU accept to broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wk_vld <= '0;
      for (int k = 0; k < FU_LATENCY; k++) begin
        r_wk_idx[k] <= '0;
      end
    end else if (flush) begin
      r_wk_vld <= '0;
    end else begin
      r_wk_vld[0] <= w_hs;
      r_wk_idx[0] <= r_issue_idx;
      for (int k = 1; k < FU_LATENCY; k++) begin
        r_wk_vld[k] <= r_wk_vld[k-1];
        r_wk_idx[k] <= r_wk_idx[k-1];
      end
    end
  end

  assign clear_en    = r_wk_vld[FU_LATENCY-1] & ~flush;
  assign clear_lines = clear_en ? (NUM_ROWS'(1) << r_wk_idx[FU_LATENCY-1]) : '0;

`ifdef ISSUE_SELECT_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_hs) r_stat_issued <= r_stat_issued + 32'd1;
      if (r_issue_valid && !issue_ready) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

  a_alloc_select_same_row : assert property (@(posedge clk) disable iff (!rst)
    !(alloc_en && w_sel && (alloc_row_index == w_sel_idx)));

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: a latency-1 and a latency-3 instance share
// stimulus; a forked monitor checks issue handshakes and wakeup broadcasts.
module tb_issue_select;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       alloc_en;
  logic [2:0] alloc_row_index;
  logic [7:0] ready_vector;
  logic       issue_ready;

  logic       free_en1, iv1, ce1;
  logic [2:0] free_idx1, iidx1;
  logic [7:0] cl1;
  logic       free_en3, iv3, ce3;
  logic [2:0] free_idx3, iidx3;
  logic [7:0] cl3;
`ifdef ISSUE_SELECT_STATS_EN
  logic [31:0] s_iss1, s_stall1, s_iss3, s_stall3;
`endif

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t iss_q[$];
  exp_t c1_q[$];
  exp_t c3_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  issue_select #(.NUM_ROWS(8), .FU_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en),
    .alloc_row_index(alloc_row_index), .ready_vector(ready_vector),
    .free_en(free_en1), .free_row_index(free_idx1), .issue_valid(iv1),
    .issue_row_index(iidx1), .issue_ready(issue_ready), .clear_en(ce1),
`ifdef ISSUE_SELECT_STATS_EN
    .clear_lines(cl1), .stat_issued(s_iss1), .stat_stall(s_stall1)
`else
    .clear_lines(cl1)
`endif
  );

  issue_select #(.NUM_ROWS(8), .FU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en),
    .alloc_row_index(alloc_row_index), .ready_vector(ready_vector),
    .free_en(free_en3), .free_row_index(free_idx3), .issue_valid(iv3),
    .issue_row_index(iidx3), .issue_ready(issue_ready), .clear_en(ce3),
`ifdef ISSUE_SELECT_STATS_EN
    .clear_lines(cl3), .stat_issued(s_iss3), .stat_stall(s_stall3)
`else
    .clear_lines(cl3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected output %0h, required none", name, act);
  endtask

  task automatic exp_issue(input int t, input int idx);
    iss_q.push_back('{cyc: t,     val: idx});
    c1_q.push_back('{cyc: t + 1,  val: 1 << idx});
    c3_q.push_back('{cyc: t + 3,  val: 1 << idx});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (iv1 && issue_ready) begin
          if (iss_q.size() == 0) spurious("issue", 32'(iidx1));
          else begin
            e = iss_q.pop_front();
            check("issue_idx", 32'(iidx1), 32'(e.val));
            check("issue_cyc", 32'(cyc), 32'(e.cyc));
          end
        end
        if (ce1) begin
          if (c1_q.size() == 0) spurious("clear_l1", 32'(cl1));
          else begin
            e = c1_q.pop_front();
            check("clear_l1_lines", 32'(cl1), 32'(e.val));
            check("clear_l1_cyc", 32'(cyc), 32'(e.cyc));
          end
        end
        if (ce3) begin
          if (c3_q.size() == 0) spurious("clear_l3", 32'(cl3));
          else begin
            e = c3_q.pop_front();
            check("clear_l3_lines", 32'(cl3), 32'(e.val));
            check("clear_l3_cyc", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  endtask

  task automatic cs();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_free(input string name, input logic en, input int idx);
    @(negedge clk);
    check({name, "_free_en"}, 32'(free_en1), 32'(en));
    check({name, "_free_idx"}, 32'(free_idx1), 32'(idx));
  endtask

  task automatic chk_zero(input string name);
    check({name, "_free_en"}, 32'(free_en1), 32'd0);
    check({name, "_free_idx"}, 32'(free_idx1), 32'd0);
    check({name, "_issue_valid"}, 32'(iv1), 32'd0);
    check({name, "_issue_idx"}, 32'(iidx1), 32'd0);
    check({name, "_clear_en"}, 32'(ce1), 32'd0);
    check({name, "_clear_lines"}, 32'(cl1), 32'd0);
    check({name, "_clear_en3"}, 32'(ce3), 32'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_row_index = '0;
    ready_vector = '0; issue_ready = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    cs(); rst = 1'b1;

    // 1: age order 5,2,7 with back-to-back issue
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd5; chk_free("t1_alloc5", 1'b0, 0);
    cs(); alloc_row_index = 3'd2; chk_free("t1_alloc2", 1'b0, 0);
    cs(); alloc_row_index = 3'd7;
    cs(); alloc_en = 1'b0; ready_vector = 8'hA4; issue_ready = 1'b1;
    exp_issue(cyc + 1, 5); exp_issue(cyc + 2, 2); exp_issue(cyc + 3, 7);
    chk_free("t1_sel5", 1'b1, 5);
    cs(); chk_free("t1_sel2", 1'b1, 2);
    cs(); chk_free("t1_sel7", 1'b1, 7);
    cs(); chk_free("t1_idle", 1'b0, 0);
    cs(); @(negedge clk); check("t1_drained_valid", 32'(iv1), 32'd0);
    ready_vector = '0;
    repeat (3) cs();

    // 2: stall holds the issue register
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd3; ready_vector = 8'h08; issue_ready = 1'b0;
    cs(); alloc_en = 1'b0; chk_free("t2_sel3", 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      cs(); @(negedge clk);
      check("t2_stall_free_en", 32'(free_en1), 32'd0);
      check("t2_stall_valid", 32'(iv1), 32'd1);
      check("t2_stall_idx", 32'(iidx1), 32'd3);
      check("t2_stall_clear", 32'(ce1), 32'd0);
    end
    cs(); issue_ready = 1'b1; exp_issue(cyc, 3); chk_free("t2_accept", 1'b0, 0);
    cs(); ready_vector = '0; @(negedge clk); check("t2_after_valid", 32'(iv1), 32'd0);
    repeat (3) cs();

    // 3: latency-3 broadcast timing for entry 6
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd6; ready_vector = 8'h40;
    cs(); alloc_en = 1'b0; chk_free("t3_sel6", 1'b1, 6);
    cs(); exp_issue(cyc, 6); @(negedge clk); check("t3_l3_t0", 32'(ce3), 32'd0);
    cs(); @(negedge clk); check("t3_l3_t1", 32'(ce3), 32'd0);
    cs(); @(negedge clk); check("t3_l3_t2", 32'(ce3), 32'd0);
    cs(); ready_vector = '0;
    cs(); @(negedge clk); check("t3_l3_t4", 32'(ce3), 32'd0);

    // 4: age beats index; alloc of another row during select
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd1;
    cs(); alloc_row_index = 3'd0;
    cs(); alloc_row_index = 3'd4; ready_vector = 8'h03;
    exp_issue(cyc + 1, 1); exp_issue(cyc + 2, 0);
    chk_free("t4_sel1", 1'b1, 1);
    cs(); alloc_en = 1'b0; chk_free("t4_sel0", 1'b1, 0);
    cs(); ready_vector = '0; chk_free("t4_idle", 1'b0, 0);
    repeat (4) cs();

    // 5: flush with issue register full and wakeup pending
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd2;
    cs(); alloc_row_index = 3'd5;
    cs(); alloc_en = 1'b0; ready_vector = 8'h24;
    iss_q.push_back('{cyc: cyc + 1, val: 2});
    chk_free("t5_sel2", 1'b1, 2);
    cs(); chk_free("t5_sel5", 1'b1, 5);
    cs(); flush = 1'b1; issue_ready = 1'b0; @(negedge clk);
    check("t5_flush_free_en", 32'(free_en1), 32'd0);
    check("t5_flush_clear_en", 32'(ce1), 32'd0);
    check("t5_flush_valid_pre", 32'(iv1), 32'd1);
    cs(); flush = 1'b0; ready_vector = '0; @(negedge clk);
    check("t5_post_valid", 32'(iv1), 32'd0);
    check("t5_post_clear", 32'(ce1), 32'd0);
    check("t5_post_clear3", 32'(ce3), 32'd0);
    cs(); @(negedge clk); check("t5_post_clear3_b", 32'(ce3), 32'd0);
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd2; ready_vector = 8'h04; issue_ready = 1'b1;
    cs(); alloc_en = 1'b0; exp_issue(cyc + 1, 2); chk_free("t5_realloc_sel2", 1'b1, 2);
    cs(); ready_vector = '0;
    repeat (4) cs();

    // 6: asynchronous reset mid-stream
    cs(); alloc_en = 1'b1; alloc_row_index = 3'd3; ready_vector = 8'h08;
    cs(); alloc_en = 1'b0; chk_free("t6_sel3", 1'b1, 3);
    cs(); iss_q.push_back('{cyc: cyc, val: 3}); @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("t6_async");
`ifdef ISSUE_SELECT_STATS_EN
    check("t6_stat_issued", s_iss1, 32'd0);
    check("t6_stat_stall", s_stall1, 32'd0);
`endif
    cs(); ready_vector = '0; issue_ready = 1'b0;
    cs(); rst = 1'b1;
    repeat (5) cs();

    check("iss_q_left", 32'(iss_q.size()), 32'd0);
    check("c1_q_left", 32'(c1_q.size()), 32'd0);
    check("c3_q_left", 32'(c3_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
